// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared constants and state encoding for the waveform sample buffer
//
// Provides the FSM state encoding (FILL/RUN/FROZEN), the default sample width
// and the screen width used as the default buffer depth.
package waveform_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SCREEN_WIDTH   = 1024;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } wf_state_e;

endpackage

// File: rtl/waveform_dpram.sv
// rtl/waveform_dpram.sv - simple dual-port read-first synchronous RAM
//
// Ports:
//   clock             write and read clock
//   wr_en/wr_addr/wr_data   write port (capture side)
//   rd_addr/rd_data   read port (display side), rd_data one clock after rd_addr
// A read of the address being written in the same cycle returns the old data.
// Contents are not reset.
module waveform_dpram #(
    parameter  int DEPTH      = 1024,
    parameter  int DATA_WIDTH = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Both accesses are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/waveform_sample_buffer.sv
// rtl/waveform_sample_buffer.sv - circular ECG sample buffer replayed per display column
//
// Captures decimated samples into a DEPTH-entry circular buffer and replays
// them indexed by hcount, with the read window snapshotted at vsync_start.
// Optional feature macro: WAVEFORM_PEAK_HOLD_EN (store group maximum instead
// of the last sample of each decimation group).
//
// Ports:
//   clock         pixel clock
//   reset_n       asynchronous active-low reset
//   sample_valid  strobe qualifying sample_in
//   sample_in     incoming sample
//   freeze        level, holds the display (no writes)
//   vsync_start   frame start pulse, latches the read window
//   hcount        current pixel column
//   signal_out    sample for hcount, two clocks late (0 when not valid)
//   signal_valid  signal_out carries stored data
//   fill_count    entries written since reset, saturating at DEPTH
//   state_out     0 FILL, 1 RUN, 2 FROZEN
module waveform_sample_buffer
    import waveform_pkg::*;
#(
    parameter  int DEPTH      = SCREEN_WIDTH,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int DECIM      = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  freeze,
    input  logic                  vsync_start,
    input  logic [10:0]           hcount,
    output logic [DATA_WIDTH-1:0] signal_out,
    output logic                  signal_valid,
    output logic [AW:0]           fill_count,
    output logic [1:0]            state_out
);

    localparam int          CW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    wf_state_e             state_q, state_d;
    wf_state_e             ret_q, ret_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         decim_cnt_q, decim_cnt_d;
    logic [AW:0]           fill_count_q, fill_count_d;
    logic [AW-1:0]         base_q, base_d;
    logic [AW:0]           snap_fill_q, snap_fill_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  in_range_q, in_range_d;
    logic                  valid_q, valid_d;

    logic                  accept;
    logic                  group_end;
    logic                  wr_en;
    logic                  run_like;
    logic [DATA_WIDTH-1:0] held_value;
    logic [DATA_WIDTH-1:0] rd_data;

`ifdef WAVEFORM_PEAK_HOLD_EN
    logic [DATA_WIDTH-1:0] peak_q, peak_d;
`endif

    // Capture side: decimator, write pointer and fill counter.
    always_comb begin
        accept       = sample_valid && (state_q != ST_FROZEN) && !freeze;
        group_end    = (decim_cnt_q == CW'(DECIM - 1));
        wr_en        = accept && group_end;
`ifdef WAVEFORM_PEAK_HOLD_EN
        // The first sample of a group restarts the running maximum.
        held_value   = ((decim_cnt_q == '0) || (sample_in > peak_q)) ? sample_in : peak_q;
        peak_d       = accept ? held_value : peak_q;
`else
        held_value   = sample_in;
`endif
        decim_cnt_d  = decim_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        fill_count_d = fill_count_q;
        if (accept) begin
            decim_cnt_d = group_end ? '0 : decim_cnt_q + CW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_count_q != FULL) begin
                fill_count_d = fill_count_q + (AW+1)'(1);
            end
        end
    end

    // Mode FSM; ret_q remembers where to go back after a freeze.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            ST_FILL: begin
                if (freeze) begin
                    state_d = ST_FROZEN;
                    ret_d   = ST_FILL;
                end else if (fill_count_q == FULL) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_FROZEN;
                    ret_d   = ST_RUN;
                end
            end
            ST_FROZEN: begin
                if (!freeze) begin
                    state_d = ret_q;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Frame snapshot and read address pipeline.
    always_comb begin
        run_like    = (state_q == ST_RUN) || ((state_q == ST_FROZEN) && (ret_q == ST_RUN));
        base_d      = base_q;
        snap_fill_d = snap_fill_q;
        // Uses the registered pointer/count, so a coincident write is not seen.
        if (vsync_start) begin
            base_d      = run_like ? wr_ptr_q : '0;
            snap_fill_d = fill_count_q;
        end
        addr_d     = base_q + hcount[AW-1:0];
        in_range_d = (32'(hcount) < 32'(snap_fill_q)) && (32'(hcount) < 32'(DEPTH));
        valid_d    = in_range_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FILL;
            ret_q        <= ST_FILL;
            wr_ptr_q     <= '0;
            decim_cnt_q  <= '0;
            fill_count_q <= '0;
            base_q       <= '0;
            snap_fill_q  <= '0;
            addr_q       <= '0;
            in_range_q   <= 1'b0;
            valid_q      <= 1'b0;
`ifdef WAVEFORM_PEAK_HOLD_EN
            peak_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            wr_ptr_q     <= wr_ptr_d;
            decim_cnt_q  <= decim_cnt_d;
            fill_count_q <= fill_count_d;
            base_q       <= base_d;
            snap_fill_q  <= snap_fill_d;
            addr_q       <= addr_d;
            in_range_q   <= in_range_d;
            valid_q      <= valid_d;
`ifdef WAVEFORM_PEAK_HOLD_EN
            peak_q       <= peak_d;
`endif
        end
    end

    waveform_dpram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (held_value),
        .rd_addr (addr_q),
        .rd_data (rd_data)
    );

    // RAM output has no reset; gating with valid_q clears the output at once.
    assign signal_out   = valid_q ? rd_data : '0;
    assign signal_valid = valid_q;
    assign fill_count   = fill_count_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_waveform_sample_buffer.sv
// tb/tb_waveform_sample_buffer.sv - self-checking bench for waveform_sample_buffer
module tb_waveform_sample_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        int         col;
        logic       v;
        logic [7:0] d;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [7:0]  sample_in;
    logic        freeze;
    logic        vsync_start;
    logic [10:0] hcount;
    logic [7:0]  signal_out;
    logic        signal_valid;
    logic [4:0]  fill_count;
    logic [1:0]  state_out;

    logic        d_valid;
    logic [7:0]  d_in;
    logic        d_freeze;
    logic [7:0]  d_out;
    logic        d_sv;
    logic [4:0]  d_fill;
    logic [1:0]  d_state;

    int          checks   = 0;
    int          failures = 0;

    logic [7:0]  m_mem [DEPTH];
    int          m_wr, m_fill, m_base, m_sfill;
    bit          m_frozen;
    exp_t        sbq [$];

    logic [7:0]  cap_out  [DEPTH];
    logic        cap_v    [DEPTH];
    logic [7:0]  dcap_out [DEPTH];
    logic        dcap_v   [DEPTH];
    logic [7:0]  dvals    [8] = '{8'd10, 8'd50, 8'd20, 8'd30, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [7:0]  dec_exp0;

    always #5 clock = ~clock;

    waveform_sample_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(8), .DECIM(1)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .freeze       (freeze),
        .vsync_start  (vsync_start),
        .hcount       (hcount),
        .signal_out   (signal_out),
        .signal_valid (signal_valid),
        .fill_count   (fill_count),
        .state_out    (state_out)
    );

    waveform_sample_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(8), .DECIM(4)) u_dec (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (d_valid),
        .sample_in    (d_in),
        .freeze       (d_freeze),
        .vsync_start  (vsync_start),
        .hcount       (hcount),
        .signal_out   (d_out),
        .signal_valid (d_sv),
        .fill_count   (d_fill),
        .state_out    (d_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [7:0] v);
        if (!m_frozen) begin
            m_mem[m_wr] = v;
            m_wr        = (m_wr + 1) % DEPTH;
            if (m_fill < DEPTH) m_fill++;
        end
    endtask

    task automatic write_burst(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            sample_in    = 8'(first + k);
            sample_valid = 1'b1;
            model_write(8'(first + k));
            @(negedge clock);
        end
        sample_valid = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clock);
        vsync_start = 1'b1;
        m_base      = (m_fill == DEPTH) ? m_wr : 0;
        m_sfill     = m_fill;
        @(negedge clock);
        vsync_start = 1'b0;
    endtask

    // Drives hcount 0..DEPTH-1 one per clock; results are compared two clocks later.
    task automatic sweep(input string name, input int wr_at, input logic [7:0] wr_val);
        exp_t e;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i >= 2) begin
                e = sbq.pop_front();
                cap_out[i-2]  = signal_out;
                cap_v[i-2]    = signal_valid;
                dcap_out[i-2] = d_out;
                dcap_v[i-2]   = d_sv;
                chk($sformatf("%s_col%0d", name, e.col),
                    {23'b0, signal_valid, signal_out}, {23'b0, e.v, e.d});
            end
            sample_valid = 1'b0;
            if (i < DEPTH) begin
                hcount = 11'(i);
                e.col  = i;
                e.v    = (i < m_sfill);
                e.d    = e.v ? m_mem[(m_base + i) % DEPTH] : 8'd0;
                sbq.push_back(e);
            end
            if (i == wr_at) begin
                sample_in    = wr_val;
                sample_valid = 1'b1;
                model_write(wr_val);
            end
            @(negedge clock);
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        freeze       = 1'b0;
        vsync_start  = 1'b0;
        hcount       = '0;
        d_valid      = 1'b0;
        d_in         = '0;
        d_freeze     = 1'b0;
        m_wr = 0; m_fill = 0; m_base = 0; m_sfill = 0; m_frozen = 0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
`ifdef WAVEFORM_PEAK_HOLD_EN
        dec_exp0 = 8'd50;
`else
        dec_exp0 = 8'd30;
`endif

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_valid", 32'(signal_valid), 32'd0);
        chk("rst_out", 32'(signal_out), 32'd0);

        // Basic capture.
        write_burst(0, 10);
        chk("basic_fill", 32'(fill_count), 32'd10);
        chk("basic_state", 32'(state_out), 32'd0);
        frame_start();
        sweep("basic", -1, 8'd0);

        // Wrap into RUN.
        write_burst(100, 20);
        frame_start();
        chk("wrap_state", 32'(state_out), 32'd1);
        chk("wrap_fill", 32'(fill_count), 32'd16);
        sweep("wrap", -1, 8'd0);
        chk("wrap_col0_const", 32'(cap_out[0]), 32'd104);
        chk("wrap_col15_const", 32'(cap_out[15]), 32'd119);

        // Freeze holds the buffer.
        freeze = 1'b1;
        repeat (2) @(negedge clock);
        chk("frz_state", 32'(state_out), 32'd2);
        m_frozen = 1;
        write_burst(60, 8);
        chk("frz_fill", 32'(fill_count), 32'd16);
        frame_start();
        sweep("frozen", -1, 8'd0);
        chk("frz_col0_const", 32'(cap_out[0]), 32'd104);
        freeze   = 1'b0;
        m_frozen = 0;
        repeat (2) @(negedge clock);
        chk("unfrz_state", 32'(state_out), 32'd1);

        // Write during a sweep: frame holds, next frame shifts by one.
        frame_start();
        sweep("live", 8, 8'd200);
        frame_start();
        sweep("shift", -1, 8'd0);
        chk("shift_col0_const", 32'(cap_out[0]), 32'd105);
        chk("shift_col15_const", 32'(cap_out[15]), 32'd200);

        // Decimation by 4 on the second instance.
        for (int k = 0; k < 8; k++) begin
            d_in    = dvals[k];
            d_valid = 1'b1;
            @(negedge clock);
        end
        d_valid = 1'b0;
        chk("dec_fill", 32'(d_fill), 32'd2);
        frame_start();
        sweep("decmain", -1, 8'd0);
        chk("dec_col0", {23'b0, dcap_v[0], dcap_out[0]}, {23'b0, 1'b1, dec_exp0});
        chk("dec_col1", {23'b0, dcap_v[1], dcap_out[1]}, {23'b0, 1'b1, 8'd8});
        chk("dec_col2", {23'b0, dcap_v[2], dcap_out[2]}, 32'd0);

        // Asynchronous reset in the middle of a frame.
        frame_start();
        hcount = 11'd3;
        repeat (2) @(negedge clock);
        chk("pre_rst_valid", {23'b0, signal_valid, signal_out}, {23'b0, 1'b1, m_mem[(m_base + 3) % DEPTH]});
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(signal_out), 32'd0);
        chk("arst_valid", 32'(signal_valid), 32'd0);
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_fill", 32'(fill_count), 32'd0);
        #2 reset_n = 1'b1;
        m_wr = 0; m_fill = 0; m_base = 0; m_sfill = 0;
        repeat (3) @(negedge clock);
        chk("post_rst_valid", 32'(signal_valid), 32'd0);
        write_burst(40, 5);
        @(negedge clock);
        chk("post_wr_valid", 32'(signal_valid), 32'd0);
        chk("post_wr_fill", 32'(fill_count), 32'd5);
        frame_start();
        sweep("post_rst", -1, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
